// File: rtl/stim_fifo_src_if.sv
// -----------------------------------------------------------------------------
// stim_fifo_src_if
// Groups the two data paths of the stimulus source:
//   memory side : mem_rden / mem_addr (source -> memory), mem_rdata (memory -> source)
//   FIFO side   : fifo_empty / fifo_data (source -> consumer), fifo_rden (consumer -> source)
// master modport : the stimulus source itself
// slave modport  : the memory plus the consumer (DTW core src_fifo port or a bench)
// -----------------------------------------------------------------------------
interface stim_fifo_src_if #(
  parameter int DWIDTH     = 16,
  parameter int AXI_DWIDTH = 32,
  parameter int ADDR_W     = 15
) ();

  logic                  mem_rden;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DWIDTH-1:0]     mem_rdata;
  logic                  fifo_rden;
  logic                  fifo_empty;
  logic [AXI_DWIDTH-1:0] fifo_data;

  modport master (
    output mem_rden,
    output mem_addr,
    input  mem_rdata,
    input  fifo_rden,
    output fifo_empty,
    output fifo_data
  );

  modport slave (
    input  mem_rden,
    input  mem_addr,
    output mem_rdata,
    output fifo_rden,
    input  fifo_empty,
    input  fifo_data
  );

endinterface

// File: rtl/stim_fifo_src.sv
// -----------------------------------------------------------------------------
// stim_fifo_src
// Replays a word image from a synchronous-read memory onto a first-word-fall-
// through source FIFO port. A start pulse selects the query or reference
// region and a word count; the block then streams the region once (or
// repeatedly in loop mode) until finished or aborted by stop. A programmable
// stall pattern can force the FIFO to look empty for part of every period.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle pulse, latches op_mode/len/loop_en (IDLE only)
//   op_mode                0 = query region, 1 = reference region
//   len                    words per pass
//   loop_en                wrap to the base address after len words
//   stop                   abort request (RUN/FLUSH only)
//   stall_period/stall_len stall pattern period and forced-empty cycles
//   bus (master)           memory read port and FWFT FIFO port
//   running                high in RUN and FLUSH
//   done                   one-cycle pulse on return to IDLE
//   words_sent             accepted pops since the last start
//   underflow              sticky, pop attempted while empty; cleared by start
// -----------------------------------------------------------------------------
module stim_fifo_src #(
  parameter int DWIDTH     = 16,
  parameter int AXI_DWIDTH = 32,
  parameter int ADDR_W     = 15,
  parameter int QRY_BASE   = 0,
  parameter int REF_BASE   = 0,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_mode,
  input  logic [CNT_W-1:0]     len,
  input  logic                 loop_en,
  input  logic                 stop,
  input  logic [7:0]           stall_period,
  input  logic [7:0]           stall_len,
  stim_fifo_src_if.master      bus,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     words_sent,
  output logic                 underflow
);

  localparam logic [ADDR_W-1:0] QRY_BASE_A = ADDR_W'(QRY_BASE);
  localparam logic [ADDR_W-1:0] REF_BASE_A = ADDR_W'(REF_BASE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                done_r, done_s;

  logic [CNT_W-1:0]    len_r;
  logic                loop_r;
  logic [ADDR_W-1:0]   base_r;

  logic [CNT_W-1:0]    issued_r, issued_next_s;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_rden_r;
  logic                wrap_r, wrap_next_s;
  logic                rvalid_r;

  logic [DWIDTH-1:0]   buf_r [2];
  logic                rd_ptr_r, wr_ptr_r;
  logic [1:0]          occ_r, occ_next_s;

  logic [7:0]          phase_r;
  logic [7:0]          eff_len_s;
  logic                stall_active_s;

  logic [CNT_W-1:0]    words_sent_r;
  logic                underflow_r;

  logic                running_s;
  logic                start_acc_s, start_go_s, abort_s;
  logic                present_s, fifo_empty_s, pop_s, store_s, room_s;
  logic [DWIDTH-1:0]   head_s;
  logic [ADDR_W-1:0]   base_sel_s;
  logic [CNT_W-1:0]    cur_len_s, cur_issued_s;
  logic                cur_loop_s, last_s, issue_s;

  assign running_s   = (state_r != ST_IDLE);
  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign start_go_s  = start_acc_s && (len != {CNT_W{1'b0}});
  assign abort_s     = running_s && stop;
  assign base_sel_s  = op_mode ? REF_BASE_A : QRY_BASE_A;

  // The word on mem_rdata (rvalid_r) counts as a buffer entry that sits behind
  // the stored ones, so it can be offered the same cycle it returns.
  assign present_s    = (occ_r != 2'd0) || rvalid_r;
  assign head_s       = (occ_r != 2'd0) ? buf_r[rd_ptr_r] : bus.mem_rdata;
  assign fifo_empty_s = !running_s || !present_s || stall_active_s;
  assign pop_s        = bus.fifo_rden && !fifo_empty_s;
  assign store_s      = rvalid_r && !(pop_s && (occ_r == 2'd0));
  assign occ_next_s   = occ_r + {1'b0, rvalid_r} - {1'b0, pop_s};
  // Entries held next cycle plus the read currently on the memory port.
  assign room_s       = ({1'b0, occ_next_s} + {2'b00, mem_rden_r}) < 3'd2;

  // Stall generator: effective forced-empty length and current stall flag.
  always_comb begin
    eff_len_s      = 8'd0;
    stall_active_s = 1'b0;
    if (stall_len < stall_period) begin
      eff_len_s = stall_len;
    end else begin
      eff_len_s = stall_period - 8'd1;
    end
    if (running_s && (stall_period >= 8'd2)) begin
      stall_active_s = (phase_r < eff_len_s);
    end else begin
      stall_active_s = 1'b0;
    end
  end

  // Issue decision; a start pulse issues the first read straight from IDLE.
  always_comb begin
    cur_len_s     = len_r;
    cur_loop_s    = loop_r;
    cur_issued_s  = issued_r;
    issued_next_s = issued_r;
    wrap_next_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      cur_len_s    = len;
      cur_loop_s   = loop_en;
      cur_issued_s = {CNT_W{1'b0}};
    end else begin
      cur_len_s    = len_r;
      cur_loop_s   = loop_r;
      cur_issued_s = issued_r;
    end
    issue_s = room_s && !abort_s &&
              (start_go_s || ((state_r == ST_RUN) && (issued_r != len_r)));
    last_s  = ((cur_issued_s + {{(CNT_W-1){1'b0}}, 1'b1}) == cur_len_s);
    if (issue_s) begin
      if (last_s && cur_loop_s) begin
        issued_next_s = {CNT_W{1'b0}};
        wrap_next_s   = 1'b1;
      end else begin
        issued_next_s = cur_issued_s + {{(CNT_W-1){1'b0}}, 1'b1};
        wrap_next_s   = 1'b0;
      end
    end else begin
      issued_next_s = cur_issued_s;
      wrap_next_s   = 1'b0;
    end
  end

  // FSM next-state and done request.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (len == {CNT_W{1'b0}})) begin
          done_s = 1'b1;
        end else if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else if (!loop_r && (issued_r == len_r)) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Leave as soon as the final pop drains the last entry.
        if (stop || ((occ_next_s == 2'd0) && !mem_rden_r)) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
        done_s  = 1'b0;
      end
    endcase
  end

  // FSM state and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_s;
    end
  end

  // Run parameters captured on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r  <= {CNT_W{1'b0}};
      loop_r <= 1'b0;
      base_r <= {ADDR_W{1'b0}};
    end else if (start_acc_s) begin
      len_r  <= len;
      loop_r <= loop_en;
      base_r <= base_sel_s;
    end else begin
      len_r  <= len_r;
      loop_r <= loop_r;
      base_r <= base_r;
    end
  end

  // Memory read port: strobe, address and return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rden_r <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      issued_r   <= {CNT_W{1'b0}};
      wrap_r     <= 1'b0;
      rvalid_r   <= 1'b0;
    end else begin
      mem_rden_r <= issue_s;
      issued_r   <= issued_next_s;
      wrap_r     <= wrap_next_s;
      rvalid_r   <= mem_rden_r && !abort_s;
      // wrap_r marks the read on the port as the last of a looped pass.
      if (start_acc_s) begin
        mem_addr_r <= base_sel_s;
      end else if (mem_rden_r) begin
        mem_addr_r <= wrap_r ? base_r : (mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1});
      end else begin
        mem_addr_r <= mem_addr_r;
      end
    end
  end

  // Two-entry storage behind the memory return register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r[0] <= {DWIDTH{1'b0}};
      buf_r[1] <= {DWIDTH{1'b0}};
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else if (abort_s) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (store_s) begin
        buf_r[wr_ptr_r] <= bus.mem_rdata;
      end
      wr_ptr_r <= wr_ptr_r ^ store_s;
      rd_ptr_r <= rd_ptr_r ^ (pop_s && (occ_r != 2'd0));
      occ_r    <= occ_next_s;
    end
  end

  // Stall phase counter, running only in RUN and FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 8'd0;
    end else if (start_acc_s || !running_s || (stall_period < 8'd2)) begin
      phase_r <= 8'd0;
    end else if (phase_r >= (stall_period - 8'd1)) begin
      phase_r <= 8'd0;
    end else begin
      phase_r <= phase_r + 8'd1;
    end
  end

  // Pop counter and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent_r <= {CNT_W{1'b0}};
      underflow_r  <= 1'b0;
    end else if (start_acc_s) begin
      words_sent_r <= {CNT_W{1'b0}};
      underflow_r  <= 1'b0;
    end else begin
      words_sent_r <= words_sent_r + {{(CNT_W-1){1'b0}}, pop_s};
      underflow_r  <= underflow_r || (bus.fifo_rden && fifo_empty_s);
    end
  end

  assign bus.mem_rden   = mem_rden_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.fifo_empty = fifo_empty_s;
  assign bus.fifo_data  = present_s ? AXI_DWIDTH'(head_s) : {AXI_DWIDTH{1'b0}};
  assign running        = running_s;
  assign done           = done_r;
  assign words_sent     = words_sent_r;
  assign underflow      = underflow_r;

endmodule

// File: tb/tb_stim_fifo_src.sv
// -----------------------------------------------------------------------------
// tb_stim_fifo_src
// Directed bench for stim_fifo_src. The memory returns its own address as
// data, so every expected word is base + index. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stim_fifo_src;

  localparam int DW  = 16;
  localparam int AXW = 32;
  localparam int ADW = 15;
  localparam int CW  = 32;
  localparam int REF = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op_mode = 1'b0;
  logic          loop_en = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] len = '0;
  logic [7:0]    stall_period = 8'd0;
  logic [7:0]    stall_len = 8'd0;
  logic          running, done, underflow;
  logic [CW-1:0] words_sent;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;

  stim_fifo_src_if #(.DWIDTH(DW), .AXI_DWIDTH(AXW), .ADDR_W(ADW)) bus ();

  stim_fifo_src #(
    .DWIDTH(DW), .AXI_DWIDTH(AXW), .ADDR_W(ADW),
    .QRY_BASE(0), .REF_BASE(REF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_mode(op_mode), .len(len),
    .loop_en(loop_en), .stop(stop), .stall_period(stall_period),
    .stall_len(stall_len), .bus(bus), .running(running), .done(done),
    .words_sent(words_sent), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory whose word equals its address.
  always @(posedge clk) begin
    if (bus.mem_rden) bus.mem_rdata <= DW'(bus.mem_addr);
  end

  // Running totals of issued reads and accepted pops.
  always @(posedge clk) begin
    if (bus.mem_rden) rd_cnt <= rd_cnt + 1;
    if (bus.fifo_rden && !bus.fifo_empty) pop_cnt <= pop_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic op, input int l, input logic lp);
    op_mode = op;
    len     = CW'(l);
    loop_en = lp;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Pops n words (only when offered, on every 'every'-th cycle) and checks order.
  task automatic drain(input string tag, input int n, input int every, input int base,
                       input int wrap_len, output int first_cyc, output int gaps,
                       output int max_out);
    int k, cyc, rd0, pop0, outst, exp_v;
    k = 0; cyc = 0; gaps = 0; first_cyc = -1; max_out = 0;
    rd0 = rd_cnt; pop0 = pop_cnt;
    while (k < n && cyc < 400) begin
      outst = (rd_cnt - rd0) - (pop_cnt - pop0) + int'(bus.mem_rden);
      if (outst > max_out) max_out = outst;
      if (!bus.fifo_empty && (cyc % every) == 0) begin
        exp_v = (wrap_len == 0) ? base + k : base + (k % wrap_len);
        bus.fifo_rden = 1'b1;
        check_eq(tag, bus.fifo_data, exp_v);
        if (k == 0) first_cyc = cyc;
        k++;
      end else begin
        bus.fifo_rden = 1'b0;
        if (k > 0 && bus.fifo_empty) gaps++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.fifo_rden = 1'b0;
    check_eq({tag, "_count"}, k, n);
  endtask

  task automatic wait_done(input string tag);
    int  cyc;
    logic seen;
    seen = 1'b0;
    for (cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq(tag, seen, 1'b1);
  endtask

  initial begin
    int f, g, m;
    bus.fifo_rden = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_empty", bus.fifo_empty, 1'b1);
    check_eq("rst_data", bus.fifo_data, 32'd0);
    check_eq("rst_rden", bus.mem_rden, 1'b0);
    check_eq("rst_running", running, 1'b0);
    check_eq("rst_words", words_sent, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass from the query region.
    do_start(1'b0, 8, 1'b0);
    check_eq("t1_lat_empty", bus.fifo_empty, 1'b1);
    drain("t1_data", 8, 1, 0, 0, f, g, m);
    check_eq("t1_first", f, 1);
    check_eq("t1_gaps", g, 0);
    check_eq("t1_done", done, 1'b1);
    check_eq("t1_running", running, 1'b0);
    check_eq("t1_words", words_sent, 32'd8);
    check_eq("t1_empty", bus.fifo_empty, 1'b1);
    @(negedge clk);
    check_eq("t1_done_pulse", done, 1'b0);

    // Reference region.
    do_start(1'b1, 4, 1'b0);
    drain("t2_data", 4, 1, REF, 0, f, g, m);
    wait_done("t2_done");
    check_eq("t2_addr", bus.mem_addr, 15'd104);

    // Stall pattern: one forced-empty cycle per six.
    stall_period = 8'd6;
    stall_len    = 8'd1;
    do_start(1'b0, 20, 1'b0);
    drain("t3_data", 20, 1, 0, 0, f, g, m);
    check_eq("t3_first", f, 1);
    check_eq("t3_gaps", g, 3);
    wait_done("t3_done");
    check_eq("t3_words", words_sent, 32'd20);
    check_eq("t3_underflow", underflow, 1'b0);
    stall_len    = 8'd0;
    stall_period = 8'd0;

    // Slow consumer: occupancy bounded, order intact.
    do_start(1'b0, 10, 1'b0);
    drain("t4_data", 10, 3, 0, 0, f, g, m);
    check_eq("t4_max_out", m, 2);
    wait_done("t4_done");
    check_eq("t4_words", words_sent, 32'd10);

    // Loop mode then stop.
    do_start(1'b0, 3, 1'b1);
    drain("t5_data", 10, 1, 0, 3, f, g, m);
    check_eq("t5_gaps", g, 0);
    check_eq("t5_running", running, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("t5_done", done, 1'b1);
    check_eq("t5_empty", bus.fifo_empty, 1'b1);
    check_eq("t5_running_off", running, 1'b0);
    check_eq("t5_words", words_sent, 32'd10);
    @(negedge clk);
    check_eq("t5_done_pulse", done, 1'b0);

    // Zero-length start.
    do_start(1'b0, 0, 1'b0);
    check_eq("t6_done", done, 1'b1);
    check_eq("t6_running", running, 1'b0);
    @(negedge clk);
    check_eq("t6_done_pulse", done, 1'b0);

    // Asynchronous reset mid-run, then replay from base.
    do_start(1'b0, 50, 1'b0);
    drain("t7_pre", 5, 1, 0, 0, f, g, m);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t7_empty", bus.fifo_empty, 1'b1);
    check_eq("t7_data", bus.fifo_data, 32'd0);
    check_eq("t7_rden", bus.mem_rden, 1'b0);
    check_eq("t7_addr", bus.mem_addr, 15'd0);
    check_eq("t7_running", running, 1'b0);
    check_eq("t7_words", words_sent, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1'b0, 2, 1'b0);
    drain("t7_replay", 2, 1, 0, 0, f, g, m);
    wait_done("t7_done");

    // Underflow is sticky until the next start.
    bus.fifo_rden = 1'b1;
    @(negedge clk);
    bus.fifo_rden = 1'b0;
    check_eq("t8_underflow", underflow, 1'b1);
    @(negedge clk);
    check_eq("t8_sticky", underflow, 1'b1);
    do_start(1'b0, 1, 1'b0);
    check_eq("t8_cleared", underflow, 1'b0);
    drain("t8_data", 1, 1, 0, 0, f, g, m);
    wait_done("t8_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stim_fifo_src.md
Name: stim_fifo_src

Overview:
- Parametrised, synthesizable stream source that replays a word image from a synchronous-read memory onto a first-word-fall-through source-FIFO interface of a DTW core.
- Supports query and reference regions, programmable empty-stall injection, loop mode and abort.
- Sits between the stimulus memory and the core's src_fifo port, in simulation benches and in on-board self-test builds.

Parameters:
DWIDTH, 16, memory word width (sample width)
AXI_DWIDTH, 32, output data width; the word is zero-extended into the low bits
ADDR_W, 15, memory address width
QRY_BASE, 0, base address of the query image (op_mode=0)
REF_BASE, 0, base address of the reference image (op_mode=1)
CNT_W, 32, width of the length and word counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches op_mode, len and loop_en; ignored while running=1
op_mode  in  1  0 = query region, 1 = reference region
len  in  CNT_W  words per pass
loop_en  in  1  1 = wrap to the base address after len words and continue until stop
stop  in  1  abort request
stall_period  in  8  stall pattern period in cycles
stall_len  in  8  forced-empty cycles per period; 0 disables stalls
mem_rden  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DWIDTH  memory data, valid exactly 1 cycle after mem_rden
fifo_rden  in  1  consumer pop request
fifo_empty  out  1  1 = no word offered
fifo_data  out  AXI_DWIDTH  head word; valid whenever fifo_empty=0
running  out  1  1 in RUN and FLUSH
done  out  1  one-cycle pulse on return to IDLE
words_sent  out  CNT_W  number of accepted pops since the last start
underflow  out  1  sticky; set by fifo_rden while fifo_empty=1; cleared by start

Behaviour:
- Reset values: fifo_empty=1, fifo_data=0, mem_rden=0, mem_addr=0, running=0, done=0, words_sent=0, underflow=0. Reset clears the FSM, buffer, counters and stall phase, including when asserted mid-operation.
- FSM states:
  - IDLE: start → RUN. mem_addr is loaded with QRY_BASE or REF_BASE according to op_mode; the issue counter, words_sent, underflow and stall phase are cleared. If start arrives with len=0, go IDLE → IDLE and pulse done the next cycle.
  - RUN: issue reads. When issued==len and loop_en=0 → FLUSH. When loop_en=1, at issued==len reset mem_addr to the base and the issue counter to 0, with no bubble required.
  - FLUSH: no new issues. When the buffer is empty and no read is in flight → IDLE with done=1 for one cycle.
  - stop in RUN or FLUSH: cancel issue, discard buffer contents and any in-flight return, → IDLE, done=1 the next cycle. stop in IDLE has no effect.
- Buffering:
  - 2-entry internal buffer.
  - Issue mem_rden when occupancy + in_flight < 2; mem_addr increments after each issue.
  - The return is written into the buffer one cycle later.
  - Sustained throughput is 1 word/cycle with no stalls.
  - First word latency is 2 cycles after start: fifo_empty falls in cycle start+2 unless a stall is active.
- Pop: fifo_rden & ~fifo_empty removes the head and increments words_sent. A simultaneous pop and write in the same cycle is legal and keeps occupancy unchanged.
- fifo_empty = IDLE | buffer empty | stall_active.
- Stall generator:
  - 8-bit phase counter runs in RUN and FLUSH, counting 0..stall_period-1, then wraps.
  - stall_active = (phase < eff_len), where eff_len = min(stall_len, stall_period-1).
  - stall_period of 0 or 1 disables stalls.
  - The phase is cleared on start.
  - Reads keep being issued during stalls until the buffer is full.
- Address wrap: mem_addr wraps modulo 2^ADDR_W silently.
- fifo_data presents mem_rdata zero-extended to AXI_DWIDTH.

Test Plan:
- len=8, op_mode=0, stall_len=0, fifo_rden=1 constant, memory word = address → words 0..7 on 8 consecutive cycles starting at start+2; done pulses after the last pop; words_sent=8.
- op_mode=1, REF_BASE=100, len=4 → first word is 100; mem_addr ends at 104.
- stall_period=6, stall_len=1, len=20, rden constant → fifo_empty high 1 of every 6 cycles; no word lost or duplicated; words_sent=20; underflow=0 because rden is masked by the bench when empty.
- Consumer pops every 3rd cycle, len=10 → buffer never exceeds 2 entries, mem_rden throttles, data order intact.
- loop_en=1, len=3, 10 pops, then stop → sequence 0,1,2,0,1,2,0,1,2,0; done one cycle after stop; fifo_empty=1.
- rst_n low mid-RUN → all outputs return to reset values immediately (asynchronously); start after release replays from the base address. A rden issued while empty sets underflow until the next start.
